// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave, ownership held for a whole wb_cyc.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int unsigned aw          = 32,
  parameter int unsigned dw          = 32,
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*aw-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*dw/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [dw-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [aw-1:0]               wbs_adr_o,
  output logic [dw-1:0]               wbs_dat_o,
  output logic [dw/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [dw-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int unsigned SW = dw / 8;
  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] nxt_grant;
  logic [IW-1:0]          last;
  logic [IW-1:0]          nxt_last;
  logic                   busy;
  logic                   fire;

  logic [aw-1:0]          s_adr;
  logic [dw-1:0]          s_dat;
  logic [SW-1:0]          s_sel;
  logic                   s_we;
  logic                   s_cyc;
  logic                   s_stb;
  logic [2:0]             s_cti;
  logic [1:0]             s_bte;

  assign busy = |grant;

  // Re-arbitrate when idle or the owner has released cyc; lowest offset from last+1 wins.
  always_comb begin
    nxt_grant = grant;
    nxt_last  = last;
    if (!(|(grant & wbm_cyc_i))) begin
      nxt_grant = '0;
      for (int i = int'(NUM_MASTERS); i >= 1; i--) begin
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
          if (wbm_cyc_i[k] && (k == (int'(last) + i) % int'(NUM_MASTERS))) begin
            nxt_grant    = '0;
            nxt_grant[k] = 1'b1;
            nxt_last     = IW'(k);
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      grant <= '0;
      last  <= IW'(NUM_MASTERS - 1);
    end else begin
      grant <= nxt_grant;
      last  <= nxt_last;
    end
  end

  // Slave-side mux from the owner; everything reads zero while idle.
  always_comb begin
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    s_we  = 1'b0;
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_cti = '0;
    s_bte = '0;
    for (int k = 0; k < int'(NUM_MASTERS); k++) begin
      if (grant[k]) begin
        s_adr = wbm_adr_i[k*aw +: aw];
        s_dat = wbm_dat_i[k*dw +: dw];
        s_sel = wbm_sel_i[k*SW +: SW];
        s_we  = wbm_we_i[k];
        s_cyc = wbm_cyc_i[k];
        s_stb = wbm_stb_i[k];
        s_cti = wbm_cti_i[k*3 +: 3];
        s_bte = wbm_bte_i[k*2 +: 2];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        stall;

  assign stall = s_cyc & s_stb & ~(wbs_ack_i | wbs_err_i | wbs_rty_i);
  assign fire  = stall && (wd_cnt == 16'(TIMEOUT));

  // Counts unterminated strobe cycles of the current owner.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt <= '0;
    end else if (fire || (nxt_grant != grant) || wbs_ack_i || wbs_err_i || wbs_rty_i) begin
      wd_cnt <= '0;
    end else if (stall) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign fire = 1'b0;
`endif

  assign wbs_adr_o = s_adr;
  assign wbs_dat_o = s_dat;
  assign wbs_sel_o = s_sel;
  assign wbs_we_o  = s_we;
  assign wbs_cyc_o = s_cyc;
  assign wbs_stb_o = s_stb & ~fire;
  assign wbs_cti_o = s_cti;
  assign wbs_bte_o = s_bte;

  assign wbm_dat_o = busy ? wbs_dat_i : '0;
  assign wbm_ack_o = grant & {NUM_MASTERS{wbs_ack_i}};
  assign wbm_err_o = grant & {NUM_MASTERS{wbs_err_i | fire}};
  assign wbm_rty_o = grant & {NUM_MASTERS{wbs_rty_i}};
  assign grant_o   = grant;
  assign timeout_o = fire;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (3 masters, TIMEOUT=16).
// Watchdog checks follow WB_ARB_TIMEOUT_EN when it is defined for the build.
module tb_wb_rr_arbiter;

  localparam int unsigned NM = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NM*32-1:0] wbm_adr_i;
  logic [NM*32-1:0] wbm_dat_i;
  logic [NM*4-1:0]  wbm_sel_i;
  logic [NM-1:0]    wbm_we_i;
  logic [NM-1:0]    wbm_cyc_i;
  logic [NM-1:0]    wbm_stb_i;
  logic [NM*3-1:0]  wbm_cti_i;
  logic [NM*2-1:0]  wbm_bte_i;
  logic [31:0]      wbm_dat_o;
  logic [NM-1:0]    wbm_ack_o;
  logic [NM-1:0]    wbm_err_o;
  logic [NM-1:0]    wbm_rty_o;
  logic [31:0]      wbs_adr_o;
  logic [31:0]      wbs_dat_o;
  logic [3:0]       wbs_sel_o;
  logic             wbs_we_o;
  logic             wbs_cyc_o;
  logic             wbs_stb_o;
  logic [2:0]       wbs_cti_o;
  logic [1:0]       wbs_bte_o;
  logic [31:0]      wbs_dat_i;
  logic             wbs_ack_i;
  logic             wbs_err_i;
  logic             wbs_rty_i;
  logic [NM-1:0]    grant_o;
  logic             timeout_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A0 = 32'hA000_0000;
  localparam logic [31:0] A1 = 32'hA000_0001;
  localparam logic [31:0] A2 = 32'hA000_0002;

  typedef struct {
    logic [2:0]  cyc;
    logic [2:0]  stb;
    logic        ack;
    logic [2:0]  exp_grant;
    logic        exp_cyc;
    logic        exp_stb;
    logic [2:0]  exp_ack;
    logic [31:0] exp_adr;
  } vec_t;

  vec_t vecs[17];

  wb_rr_arbiter #(.aw(32), .dw(32), .NUM_MASTERS(NM), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] c, input logic [2:0] s);
    wbm_cyc_i = c;
    wbm_stb_i = s;
  endtask

  initial begin
    wbm_adr_i = {A2, A1, A0};
    wbm_dat_i = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    wbm_sel_i = {4'h4, 4'h2, 4'h1};
    wbm_we_i  = 3'b101;
    wbm_cti_i = '0;
    wbm_bte_i = '0;
    set_req(3'b000, 3'b000);
    wbs_dat_i = 32'h1234_5678;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;

    //              cyc     stb     ack   grant   cyc   stb   ack     adr
    vecs[0]  = '{3'b011, 3'b011, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, A0};
    vecs[1]  = '{3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001, A0};
    vecs[2]  = '{3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, A1};
    vecs[3]  = '{3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010, A1};
    vecs[4]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0};
    vecs[5]  = '{3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 1'b1, 3'b100, A2};
    vecs[6]  = '{3'b011, 3'b011, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, A0};
    vecs[7]  = '{3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001, A0};
    vecs[8]  = '{3'b110, 3'b110, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, A1};
    vecs[9]  = '{3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010, A1};
    vecs[10] = '{3'b101, 3'b101, 1'b0, 3'b100, 1'b1, 1'b1, 3'b000, A2};
    vecs[11] = '{3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 1'b1, 3'b100, A2};
    vecs[12] = '{3'b011, 3'b011, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000, A0};
    vecs[13] = '{3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001, A0};
    vecs[14] = '{3'b110, 3'b110, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000, A1};
    vecs[15] = '{3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010, A1};
    vecs[16] = '{3'b111, 3'b101, 1'b1, 3'b010, 1'b1, 1'b0, 3'b010, A1};

    do_reset();
    chk("reset_grant", 32'(grant_o), 32'h0);
    chk("reset_cyc", 32'(wbs_cyc_o), 32'h0);
    chk("reset_adr", wbs_adr_o, 32'h0);
    chk("reset_timeout", 32'(timeout_o), 32'h0);

    // Table: arbitration, handover, lost bus on re-raise, gating of non-owners.
    for (int i = 0; i < 17; i++) begin
      set_req(vecs[i].cyc, vecs[i].stb);
      wbs_ack_i = vecs[i].ack;
      step();
      chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(vecs[i].exp_grant));
      chk($sformatf("v%0d_cyc", i), 32'(wbs_cyc_o), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_stb", i), 32'(wbs_stb_o), 32'(vecs[i].exp_stb));
      chk($sformatf("v%0d_ack", i), 32'(wbm_ack_o), 32'(vecs[i].exp_ack));
      chk($sformatf("v%0d_adr", i), wbs_adr_o, vecs[i].exp_adr);
    end
    wbs_ack_i = 1'b0;

    // Round-robin order 0,1,2,0,1,2 with single-beat cycles.
    set_req(3'b000, 3'b000);
    do_reset();
    set_req(3'b111, 3'b111);
    step();
    chk("rr_first", 32'(grant_o), 32'h1);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] own;
      logic [2:0] nxt;
      own = 3'(1 << (i % 3));
      nxt = 3'(1 << ((i + 1) % 3));
      wbs_ack_i = 1'b1;
      #1;
      chk($sformatf("rr%0d_ack", i), 32'(wbm_ack_o), 32'(own));
      wbs_ack_i = 1'b0;
      set_req(3'b111 & ~own, 3'b111 & ~own);
      step();
      chk($sformatf("rr%0d_next", i), 32'(grant_o), 32'(nxt));
      set_req(3'b111, 3'b111);
      step();
      chk($sformatf("rr%0d_hold", i), 32'(grant_o), 32'(nxt));
    end

    // Eight-beat incrementing burst by master 1 while master 0 waits.
    set_req(3'b000, 3'b000);
    do_reset();
    set_req(3'b010, 3'b010);
    step();
    chk("burst_grant", 32'(grant_o), 32'h2);
    set_req(3'b011, 3'b011);
    for (int b = 0; b < 8; b++) begin
      wbm_cti_i[5:3] = (b == 7) ? 3'b111 : 3'b010;
      wbs_ack_i = 1'b1;
      #1;
      chk($sformatf("burst%0d_ack", b), 32'(wbm_ack_o), 32'h2);
      chk($sformatf("burst%0d_cti", b), 32'(wbs_cti_o), (b == 7) ? 32'h7 : 32'h2);
      step();
      chk($sformatf("burst%0d_grant", b), 32'(grant_o), 32'h2);
    end
    wbs_ack_i = 1'b0;
    wbm_cti_i = '0;
    set_req(3'b001, 3'b001);
    step();
    chk("burst_handover", 32'(grant_o), 32'h1);
    chk("burst_handover_adr", wbs_adr_o, A0);

    // Reset asserted on beat 3 of a burst, then re-arbitration from master 0.
    set_req(3'b000, 3'b000);
    do_reset();
    set_req(3'b010, 3'b010);
    step();
    set_req(3'b011, 3'b011);
    wbm_cti_i[5:3] = 3'b010;
    wbs_ack_i = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_grant", 32'(grant_o), 32'h0);
    chk("rstmid_cyc", 32'(wbs_cyc_o), 32'h0);
    chk("rstmid_ack", 32'(wbm_ack_o), 32'h0);
    wbs_ack_i = 1'b0;
    wbm_cti_i = '0;
    step();
    chk("rstmid_regrant", 32'(grant_o), 32'h1);

    // Error/retry routing and data paths for owner master 0.
    wbs_err_i = 1'b1;
    #1;
    chk("err_route", 32'(wbm_err_o), 32'h1);
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b1;
    #1;
    chk("rty_route", 32'(wbm_rty_o), 32'h1);
    wbs_rty_i = 1'b0;
    #1;
    chk("rdata", wbm_dat_o, 32'h1234_5678);
    chk("wdata", wbs_dat_o, 32'hD000_0000);
    chk("sel", 32'(wbs_sel_o), 32'h1);
    chk("we", 32'(wbs_we_o), 32'h1);

`ifdef WB_ARB_TIMEOUT_EN
    // Stalled slave: watchdog fires exactly 16 cycles after stb.
    set_req(3'b000, 3'b000);
    do_reset();
    set_req(3'b001, 3'b001);
    step();
    for (int t = 0; t <= 16; t++) begin
      chk($sformatf("wd%0d_timeout", t), 32'(timeout_o), (t == 16) ? 32'h1 : 32'h0);
      chk($sformatf("wd%0d_err", t), 32'(wbm_err_o), (t == 16) ? 32'h1 : 32'h0);
      chk($sformatf("wd%0d_stb", t), 32'(wbs_stb_o), (t == 16) ? 32'h0 : 32'h1);
      if (t < 16) step();
    end
    // Ack arriving on the limit cycle wins over the watchdog.
    set_req(3'b000, 3'b000);
    do_reset();
    set_req(3'b001, 3'b001);
    step();
    repeat (16) step();
    wbs_ack_i = 1'b1;
    #1;
    chk("wdack_ack", 32'(wbm_ack_o), 32'h1);
    chk("wdack_err", 32'(wbm_err_o), 32'h0);
    chk("wdack_timeout", 32'(timeout_o), 32'h0);
    wbs_ack_i = 1'b0;
`else
    // Without the watchdog a stalled slave keeps the bus.
    set_req(3'b000, 3'b000);
    do_reset();
    set_req(3'b011, 3'b011);
    step();
    repeat (20) begin
      step();
      chk("stall_timeout", 32'(timeout_o), 32'h0);
    end
    chk("stall_grant", 32'(grant_o), 32'h1);
    chk("stall_stb", 32'(wbs_stb_o), 32'h1);
    chk("stall_err", 32'(wbm_err_o), 32'h0);
`endif

    set_req(3'b000, 3'b000);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone B3 arbiter sharing one slave port between NUM_MASTERS masters (typically several BFM transactors driving one memory model in a testbench, or several cores in synthesisable designs). Ownership is granted per bus cycle (whole wb_cyc assertion, including registered-feedback bursts with CTI/BTE), so bursts are never split. An optional watchdog terminates stalled cycles with an error.

## Interface
- aw, 32, address width
- dw, 32, data width; sel width dw/8
- NUM_MASTERS, 2, number of masters, 2..8
- TIMEOUT, 255, watchdog limit in cycles (used only with the watchdog macro), 1..65535
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; one clock, synchronous, active-high
- wbm_adr_i  in  NUM_MASTERS*aw  master addresses, master k at [k*aw +: aw]
- wbm_dat_i  in  NUM_MASTERS*dw  master write data
- wbm_sel_i  in  NUM_MASTERS*dw/8  byte selects
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS  per-master controls
- wbm_cti_i  in  NUM_MASTERS*3  cycle type; wbm_bte_i  in  NUM_MASTERS*2  burst type
- wbm_dat_o  out  dw  read data, broadcast to all masters
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS  terminations, granted master only
- wbs_adr_o  out  aw; wbs_dat_o  out  dw; wbs_sel_o  out  dw/8; wbs_we_o, wbs_cyc_o, wbs_stb_o  out  1; wbs_cti_o  out  3; wbs_bte_o  out  2  slave side
- wbs_dat_i  in  dw; wbs_ack_i, wbs_err_i, wbs_rty_i  in  1  slave responses
- grant_o  out  NUM_MASTERS  one-hot current owner, all-zero when idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

## Operation
- State: grant register (one-hot or zero) plus last-owner index `last`.
- Each edge: if grant is zero or the granted master's wbm_cyc_i is low, grant := first master with cyc high searching from last+1 upward modulo NUM_MASTERS (zero if none); last := new owner when nonzero. Otherwise grant holds.
- Slave outputs mux from the granted master; wbs_cyc_o/wbs_stb_o = granted master's cyc/stb ANDed with grant valid; all slave outputs 0 when idle.
- wbm_ack_o[k]/err/rty = slave response AND grant[k]; non-granted masters see 0.
- Masters never see a response when not granted, even if they assert stb.
- Reset: grant 0, last = NUM_MASTERS-1 (master 0 has first priority), all outputs 0, watchdog counter 0.

## Timing
- Request-to-grant: master raises cyc in cycle N (bus idle), grant_o and wbs_cyc_o high in cycle N+1.
- Handover: owner drops cyc in cycle N; next owner drives slave in cycle N+1 (no extra idle cycle).
- Owner dropping cyc and re-raising it in cycle N+1 loses the bus if another master is requesting.
- Combinational paths: master controls -> slave outputs, slave responses -> master terminations (zero latency, within the owner's cycle).
- Reset asserted mid-burst: next cycle grant 0, wbs_cyc_o 0; requests re-arbitrated from master 0.

## Configuration
- WB_ARB_TIMEOUT_EN defined: 16-bit counter increments each cycle wbs_cyc_o&wbs_stb_o with no ack/err/rty, clears on any termination or grant change. On reaching TIMEOUT: wbm_err_o of owner and timeout_o pulse high for one cycle, wbs_stb_o forced 0 that cycle, counter clears. Slave ack/err/rty arriving in the same cycle wins; no timeout then.
- Not defined: no counter; timeout_o tied 0; stalled slave holds the bus indefinitely.

## Test plan
- Reset, masters 0 and 1 raise cyc same cycle -> master 0 granted next cycle; after it drops cyc, master 1 granted the following cycle.
- Three masters requesting continuously, single-beat cycles -> grant order 0,1,2,0,1,2.
- Master 1 runs 8-beat incrementing burst (cti 010 ... 111, bte 00) while master 0 requests -> all 8 acks to master 1, master 0 granted only after master 1 cyc drops.
- Non-granted master asserts stb with slave ack high -> its ack/err/rty stay 0, slave outputs unchanged.
- Reset asserted on beat 3 of a burst -> wbs_cyc_o 0 and grant_o 0 next cycle.
- WB_ARB_TIMEOUT_EN, TIMEOUT=16, slave never acks -> err and timeout_o pulse exactly 16 cycles after stb; with ack on cycle 16 -> ack, no err.
